spi_xfer_sequencer: RTL and testbench

Bus-master sequencer that drives the SPI controller's peripheral register port on behalf of two requesters (core and DMA). Grants one requester at a time using round-robin arbitration. Performs the fixed access sequence for one transfer: configure, poll SPTEF, write TX word, poll SPIF, read RX word. Returns the received word or an error to the granted requester.

---
 rtl/spi_seq_pkg.sv | 42 ++++
 rtl/spi_rr_arb2.sv | 40 ++++
 rtl/spi_xfer_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_spi_xfer_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// Shared constants and types for the SPI transfer sequencer.
//   - Peripheral register addresses (8-bit offsets, zero-extended to ADDR_W).
//   - SPISR bit positions as seen in PRDATA[7:0] on a status read.
//   - err_code encodings reported with done.
//   - FSM state encoding and the debug view struct exported by the top.
package spi_seq_pkg;

    localparam logic [7:0] SPI_A_CFG  = 8'h00;
    localparam logic [7:0] SPI_A_TX   = 8'h04;
    localparam logic [7:0] SPI_A_RX   = 8'h08;
    localparam logic [7:0] SPI_A_IDLE = 8'h0C;

    localparam int SPIF  = 7;
    localparam int SPTEF = 5;
    localparam int MODF  = 4;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_MODF    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE   = 4'd0;
    localparam state_t ST_ARB    = 4'd1;
    localparam state_t ST_CFG    = 4'd2;
    localparam state_t ST_TE_REQ = 4'd3;
    localparam state_t ST_TE_CHK = 4'd4;
    localparam state_t ST_WR     = 4'd5;
    localparam state_t ST_F_REQ  = 4'd6;
    localparam state_t ST_F_CHK  = 4'd7;
    localparam state_t ST_RD     = 4'd8;
    localparam state_t ST_RD_CAP = 4'd9;
    localparam state_t ST_DONE   = 4'd10;

    // Registered debug view: FSM state, current poll count, last SPISR pin value.
    typedef struct packed {
        state_t     state;
        logic [7:0] poll_cnt;
        logic [7:0] spisr;
    } seq_dbg_t;

endpackage

// File: rtl/spi_rr_arb2.sv
// Two-input round-robin arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   req      : request bits
//   adv      : strobe; when high and a grant is offered, the winner becomes
//              the last-granted requester
//   grant    : one-hot (or zero) combinational grant offer
// On a tie the requester that was not granted last wins. The last-grant
// pointer resets to 1 so requester 0 wins the first tie.
module spi_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] grant
);

    logic last_q;
    logic last_d;

    always_comb begin
        if (req == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
        last_d = last_q;
        if (adv && (grant != 2'b00)) begin
            last_d = grant[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Bus-master sequencer driving the SPI controller's register port for two
// requesters (0 = core, 1 = DMA). One transfer: write config, poll SPTEF,
// write TX word, poll SPIF, read RX word, report result.
// Ports:
//   PCLK, PRESET              clock, asynchronous active-high reset
//   req[1:0]                  level requests, held until the matching gnt
//   req_cfg0/1, req_wdata0/1  per-requester config image and TX word
//   gnt[1:0]                  one-cycle one-hot accept pulse
//   done, done_id, rdata,     end-of-transfer pulse with owner, RX word
//   err, err_code             (0 on error) and error status
//   PSEL, PWRITE, PADDR,      peripheral access, 1-cycle select pulses
//   PWDATA, PRDATA            (PRDATA is registered by the peripheral)
//   SPISR                     status pins, registered into the debug view
//   dbg                       registered state / poll count / status view
// All outputs come straight from flops. Bus and handshake outputs are
// computed from the next state so they are valid in the cycle the FSM sits
// in the corresponding state.
module spi_xfer_sequencer
    import spi_seq_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int POLL_MAX = 255
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [1:0]        req,
    input  logic [23:0]       req_cfg0,
    input  logic [23:0]       req_cfg1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        gnt,
    output logic              done,
    output logic              done_id,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              PSEL,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic [7:0]        SPISR,
    output seq_dbg_t          dbg
);

    // Index of the last permitted poll in a wait phase (counter starts at 0).
    localparam logic [7:0] POLL_LAST = 8'(POLL_MAX - 1);

    state_t            state_q,    state_d;
    logic [7:0]        poll_cnt_q, poll_cnt_d;
    logic              owner_q,    owner_d;
    logic [23:0]       cfg_q,      cfg_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic [1:0]        gnt_q,      gnt_d;
    logic              done_q,     done_d;
    logic              done_id_q,  done_id_d;
    logic [DATA_W-1:0] rdata_q,    rdata_d;
    logic              err_q,      err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              psel_q,     psel_d;
    logic              pwrite_q,   pwrite_d;
    logic [ADDR_W-1:0] paddr_q,    paddr_d;
    logic [DATA_W-1:0] pwdata_q,   pwdata_d;
    logic [7:0]        spisr_q,    spisr_d;

    logic [1:0] arb_gnt;
    logic       arb_adv;
    logic       chk_bit;
    logic       in_te;

    spi_rr_arb2 u_arb (
        .clk   (PCLK),
        .rst   (PRESET),
        .req   (req),
        .adv   (arb_adv),
        .grant (arb_gnt)
    );

    always_comb begin
        state_d    = state_q;
        poll_cnt_d = poll_cnt_q;
        owner_d    = owner_q;
        cfg_d      = cfg_q;
        wdata_d    = wdata_q;
        gnt_d      = 2'b00;
        done_d     = 1'b0;
        done_id_d  = done_id_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        spisr_d    = SPISR;
        arb_adv    = 1'b0;
        in_te      = (state_q == ST_TE_CHK);
        chk_bit    = in_te ? PRDATA[SPTEF] : PRDATA[SPIF];

        case (state_q)
            // The winner is chosen on the IDLE->ARB edge so that the
            // registered gnt pulse lands in the ARB cycle.
            ST_IDLE: begin
                if (arb_gnt != 2'b00) begin
                    state_d = ST_ARB;
                    arb_adv = 1'b1;
                    gnt_d   = arb_gnt;
                    owner_d = arb_gnt[1];
                    cfg_d   = arb_gnt[1] ? req_cfg1 : req_cfg0;
                    wdata_d = arb_gnt[1] ? req_wdata1 : req_wdata0;
                end
            end
            ST_ARB:    state_d = ST_CFG;
            ST_CFG: begin
                state_d    = ST_TE_REQ;
                poll_cnt_d = '0;
            end
            ST_TE_REQ: state_d = ST_TE_CHK;
            // Priority: MODF abort, then condition bit, then timeout.
            ST_TE_CHK, ST_F_CHK: begin
                if (PRDATA[MODF]) begin
                    state_d    = ST_DONE;
                    err_d      = 1'b1;
                    err_code_d = ERR_MODF;
                    rdata_d    = '0;
                end else if (chk_bit) begin
                    state_d = in_te ? ST_WR : ST_RD;
                end else if (poll_cnt_q == POLL_LAST) begin
                    state_d    = ST_DONE;
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    rdata_d    = '0;
                end else begin
                    poll_cnt_d = poll_cnt_q + 8'd1;
                    state_d    = in_te ? ST_TE_REQ : ST_F_REQ;
                end
            end
            ST_WR: begin
                state_d    = ST_F_REQ;
                poll_cnt_d = '0;
            end
            ST_F_REQ:  state_d = ST_F_CHK;
            ST_RD:     state_d = ST_RD_CAP;
            ST_RD_CAP: begin
                state_d    = ST_DONE;
                err_d      = 1'b0;
                err_code_d = ERR_NONE;
                rdata_d    = PRDATA;
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (state_d == ST_DONE) begin
            done_d    = 1'b1;
            done_id_d = owner_q;
        end
    end

    // Bus drive for the coming cycle. Status reads also carry the config
    // image because the peripheral reloads its config on those reads.
    always_comb begin
        psel_d   = 1'b0;
        pwrite_d = 1'b0;
        paddr_d  = ADDR_W'(SPI_A_IDLE);
        pwdata_d = '0;
        case (state_d)
            ST_CFG: begin
                psel_d   = 1'b1;
                pwrite_d = 1'b1;
                paddr_d  = ADDR_W'(SPI_A_CFG);
                pwdata_d = DATA_W'(cfg_d);
            end
            ST_TE_REQ, ST_F_REQ: begin
                psel_d   = 1'b1;
                paddr_d  = ADDR_W'(SPI_A_CFG);
                pwdata_d = DATA_W'(cfg_d);
            end
            ST_WR: begin
                psel_d   = 1'b1;
                pwrite_d = 1'b1;
                paddr_d  = ADDR_W'(SPI_A_TX);
                pwdata_d = wdata_d;
            end
            ST_RD: begin
                psel_d  = 1'b1;
                paddr_d = ADDR_W'(SPI_A_RX);
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q    <= ST_IDLE;
            poll_cnt_q <= '0;
            owner_q    <= 1'b0;
            cfg_q      <= '0;
            wdata_q    <= '0;
            gnt_q      <= 2'b00;
            done_q     <= 1'b0;
            done_id_q  <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            psel_q     <= 1'b0;
            pwrite_q   <= 1'b0;
            paddr_q    <= ADDR_W'(SPI_A_IDLE);
            pwdata_q   <= '0;
            spisr_q    <= '0;
        end else begin
            state_q    <= state_d;
            poll_cnt_q <= poll_cnt_d;
            owner_q    <= owner_d;
            cfg_q      <= cfg_d;
            wdata_q    <= wdata_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            done_id_q  <= done_id_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            psel_q     <= psel_d;
            pwrite_q   <= pwrite_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            spisr_q    <= spisr_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign done_id  = done_id_q;
    assign rdata    = rdata_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign PSEL     = psel_q;
    assign PWRITE   = pwrite_q;
    assign PADDR    = paddr_q;
    assign PWDATA   = pwdata_q;
    assign dbg      = '{state: state_q, poll_cnt: poll_cnt_q, spisr: spisr_q};

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Bench for spi_xfer_sequencer. A behavioural peripheral answers status and
// RX reads; stimulus pushes expected grants and completions into queues; a
// negedge monitor checks the bus and pops/compares on gnt and done.
module tb_spi_xfer_sequencer;
    import spi_seq_pkg::*;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int POLL_MAX = 4;
    localparam int EXP_W    = 54;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic [1:0]        req = 2'b00;
    logic [23:0]       cfg0 = 24'h000301;
    logic [23:0]       cfg1 = 24'h020502;
    logic [DATA_W-1:0] wdata0 = 32'hA5A5_0001;
    logic [DATA_W-1:0] wdata1 = 32'h5A5A_0002;
    logic [1:0]        gnt;
    logic              done, done_id, err;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        err_code;
    logic              PSEL, PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA = '0;
    logic [7:0]        SPISR = 8'h00;
    seq_dbg_t          dbg;

    spi_xfer_sequencer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .POLL_MAX(POLL_MAX)
    ) dut (
        .PCLK(clk), .PRESET(rst), .req(req),
        .req_cfg0(cfg0), .req_cfg1(cfg1),
        .req_wdata0(wdata0), .req_wdata1(wdata1),
        .gnt(gnt), .done(done), .done_id(done_id), .rdata(rdata),
        .err(err), .err_code(err_code),
        .PSEL(PSEL), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .SPISR(SPISR), .dbg(dbg)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [1:0]       gnt_exp_q[$];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req_v, cyc);
        end
    endtask

    function automatic logic [EXP_W-1:0] pack_exp(input logic id, input logic e, input logic [1:0] code,
                                                   input logic [31:0] rd, input logic [7:0] lat,
                                                   input logic [3:0] nte, input logic [3:0] nf,
                                                   input logic [1:0] ntx);
        return {id, e, code, rd, lat, nte, nf, ntx};
    endfunction

    // ---------------- peripheral model ----------------
    int   te_delay = 0;
    int   f_delay  = 0;
    logic modf_te  = 1'b0;
    logic [31:0] rx_word = 32'h1234_5678;
    int   p_te = 0;
    int   p_f  = 0;
    logic p_in_f = 1'b0;

    // Base status 0xA0 (SPIF|SPTEF); condition bits withheld for the first
    // *_delay polls of their phase; MODF optionally forced during TE polls.
    function automatic logic [7:0] status_fn(input logic in_f, input int n);
        logic [7:0] sr;
        sr = 8'hA0;
        if (!in_f) begin
            if (n <= te_delay) sr[5] = 1'b0;
            if (modf_te) sr[4] = 1'b1;
        end else begin
            if (n <= f_delay) sr[7] = 1'b0;
        end
        return sr;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                p_te = 0; p_f = 0; p_in_f = 1'b0;
                PRDATA <= '0;
            end else if (PSEL) begin
                if (PWRITE) begin
                    if (PADDR == 32'h0) begin
                        p_te = 0; p_f = 0; p_in_f = 1'b0;
                    end else if (PADDR == 32'h4) begin
                        p_in_f = 1'b1;
                    end
                end else if (PADDR == 32'h0) begin
                    if (!p_in_f) begin
                        p_te = p_te + 1;
                        PRDATA <= {24'h0, status_fn(1'b0, p_te)};
                        SPISR  <= status_fn(1'b0, p_te);
                    end else begin
                        p_f = p_f + 1;
                        PRDATA <= {24'h0, status_fn(1'b1, p_f)};
                        SPISR  <= status_fn(1'b1, p_f);
                    end
                end else if (PADDR == 32'h8) begin
                    PRDATA <= rx_word;
                end else begin
                    PRDATA <= '0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int          gnt_cyc = 0;
    int          last_done_cyc = 0;
    logic        m_in_f = 1'b0;
    int          m_nte = 0, m_nf = 0, m_ntx = 0;
    logic [23:0] cur_cfg = '0;
    logic [31:0] cur_wdata = '0;
    logic        b2b_mode = 1'b0;
    int          b2b_cnt = 0;
    logic [1:0]  mon_g;
    logic [EXP_W-1:0] mon_e;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (gnt != 2'b00) begin
                    if (gnt_exp_q.size() == 0) begin
                        chk("unexpected_gnt", gnt, 2'b00);
                    end else begin
                        mon_g = gnt_exp_q.pop_front();
                        chk("gnt", gnt, mon_g);
                        cur_cfg   = mon_g[1] ? cfg1 : cfg0;
                        cur_wdata = mon_g[1] ? wdata1 : wdata0;
                    end
                    if (b2b_mode) begin
                        if (b2b_cnt > 0) chk("b2b_gap", cyc - last_done_cyc, 2);
                        b2b_cnt++;
                    end
                    gnt_cyc = cyc;
                    m_in_f = 1'b0; m_nte = 0; m_nf = 0; m_ntx = 0;
                end
                if (PSEL) begin
                    if (PADDR == 32'h0 && !PWRITE) begin
                        chk("status_rd_pwdata", PWDATA, {8'h00, cur_cfg});
                        if (m_in_f) m_nf++; else m_nte++;
                    end else if (PADDR == 32'h0 && PWRITE) begin
                        chk("cfg_wr_pwdata", PWDATA, {8'h00, cur_cfg});
                    end else if (PADDR == 32'h4) begin
                        chk("tx_wr", {PWRITE, PWDATA}, {1'b1, cur_wdata});
                        m_ntx++;
                        m_in_f = 1'b1;
                    end else begin
                        chk("rx_rd", {PWRITE, PADDR}, {1'b0, 32'h8});
                    end
                end else begin
                    chk("idle_bus", {PWRITE, PADDR, PWDATA}, {1'b0, 32'h0C, 32'h0});
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", done, 1'b0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("done_id",  done_id,       mon_e[53]);
                        chk("err",      err,           mon_e[52]);
                        chk("err_code", err_code,      mon_e[51:50]);
                        chk("rdata",    rdata,         mon_e[49:18]);
                        chk("latency",  cyc - gnt_cyc, mon_e[17:10]);
                        chk("te_polls", m_nte,         mon_e[9:6]);
                        chk("f_polls",  m_nf,          mon_e[5:2]);
                        chk("tx_writes", m_ntx,        mon_e[1:0]);
                    end
                    last_done_cyc = cyc;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_any_gnt();
        int k;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (gnt == 2'b00 && k < 100);
        if (gnt == 2'b00) chk("gnt_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic single_xfer(input logic id, input logic [EXP_W-1:0] e);
        gnt_exp_q.push_back(id ? 2'b10 : 2'b01);
        exp_q.push_back(e);
        req[id] = 1'b1;
        wait_any_gnt();
        req = 2'b00;
        wait_drain();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bus", {PSEL, PWRITE, PADDR, PWDATA}, {1'b0, 1'b0, 32'h0C, 32'h0});
        chk("rst_resp", {gnt, done, done_id, err, err_code, rdata}, '0);
        chk("rst_state", dbg.state, ST_IDLE);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Nominal transfer, requester 0: done 9 cycles after gnt.
        single_xfer(1'b0, pack_exp(1'b0, 1'b0, 2'b00, 32'h1234_5678, 8'd9, 4'd1, 4'd1, 2'd1));

        // Requester 1, SPIF low for 3 polls: 4 F polls, 6 extra cycles.
        f_delay = 3;
        rx_word = 32'h0BAD_F00D;
        single_xfer(1'b1, pack_exp(1'b1, 1'b0, 2'b00, 32'h0BAD_F00D, 8'd15, 4'd1, 4'd4, 2'd1));
        f_delay = 0;

        // Both held: last grant was 1, so 0,1,0,1 with one IDLE cycle between.
        rx_word = 32'hCAFE_0003;
        for (int i = 0; i < 4; i++) begin
            gnt_exp_q.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
            exp_q.push_back(pack_exp(i[0], 1'b0, 2'b00, 32'hCAFE_0003, 8'd9, 4'd1, 4'd1, 2'd1));
        end
        b2b_mode = 1'b1;
        b2b_cnt  = 0;
        req = 2'b11;
        for (int i = 0; i < 4; i++) wait_any_gnt();
        req = 2'b00;
        wait_drain();
        b2b_mode = 1'b0;

        // MODF together with SPTEF on the first TE poll: MODF wins, no TX write.
        modf_te = 1'b1;
        single_xfer(1'b0, pack_exp(1'b0, 1'b1, 2'b01, 32'h0, 8'd4, 4'd1, 4'd0, 2'd0));
        modf_te = 1'b0;

        // SPTEF stuck low: timeout after POLL_MAX (4) TE polls.
        te_delay = 1000;
        single_xfer(1'b1, pack_exp(1'b1, 1'b1, 2'b10, 32'h0, 8'd10, 4'd4, 4'd0, 2'd0));
        te_delay = 0;

        // Reset in cycle 6 of a requester-0 transfer: bus idles at once, no done.
        gnt_exp_q.push_back(2'b01);
        req = 2'b01;
        wait_any_gnt();
        req = 2'b00;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_bus", {PSEL, PWRITE, PADDR, PWDATA}, {1'b0, 1'b0, 32'h0C, 32'h0});
        chk("midrst_resp", {gnt, done, err, err_code, rdata}, '0);
        chk("midrst_state", dbg.state, ST_IDLE);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // Pointer was reset to 1, so requester 0 wins this tie.
        gnt_exp_q.push_back(2'b01);
        exp_q.push_back(pack_exp(1'b0, 1'b0, 2'b00, 32'hCAFE_0003, 8'd9, 4'd1, 4'd1, 2'd1));
        req = 2'b11;
        wait_any_gnt();
        req = 2'b00;
        wait_drain();

        chk("gnt_queue_empty", gnt_exp_q.size(), 0);
        chk("exp_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
